shift_barrel_arbiter: RTL
=========================

// Module: shift_barrel_arbiter
// PURPOSE
//  Shares one combinational fast left barrel shifter among Nreq requesters.
//  Each requester offers an operand and shift amount over valid/ready. A round-robin arbiter grants one per cycle.
//  The result is registered and returned on a single tagged response channel with backpressure.
//  Sits between issue slots of the integer datapath and the shared shift unit.
// PARAMETERS
//  Bits  64  operand/result width, power of 2 >= 2; SHW = `log2(Bits)
//  Nreq  4   number of requesters, 2..16; IDW = `log2(Nreq) (min 1)
// PORTS
//  clk         in   1          clock, all state on rising edge
//  reset_n     in   1          asynchronous, active-low reset
//  req_valid   in   Nreq       requester i has a request
//  req_ready   out  Nreq       one-hot (or 0) grant; handshake when valid&ready
//  req_a       in   Nreq*Bits  operand, requester i at [i*Bits +: Bits]
//  req_sh      in   Nreq*SHW   shift amount, requester i at [i*SHW +: SHW]
//  resp_valid  out  1          registered result available
//  resp_ready  in   1          consumer accepts result
//  resp_b      out  Bits       a << sh, zero-filled, truncated to Bits
//  resp_id     out  IDW        index of requester that produced resp_b
// BEHAVIOUR
//  - Reset (async assert, sync release): resp_valid=0, resp_b=0, resp_id=0, rr_ptr=0.
//    req_ready is forced 0 while reset_n=0.
//  - Output stage is one register slot. can_accept = !resp_valid | resp_ready.
//  - Arbitration (combinational): if can_accept, grant lowest i >= rr_ptr (circular)
//    with req_valid[i]=1. req_ready[i]=1 only for that i; all others 0.
//    req_ready never depends on req_valid[j] of a non-granted requester beyond the priority scan.
//  - On grant of i: next cycle resp_valid=1, resp_b=req_a[i]<<req_sh[i], resp_id=i.
//    rr_ptr <= (i+1) mod Nreq. Latency is exactly 1 cycle from handshake to resp_valid.
//  - No grant and resp_ready & resp_valid: resp_valid<=0. resp_b and resp_id hold their last value.
//  - resp_valid & !resp_ready: resp_b/resp_id held stable and no new grant is issued (full).
//  - Simultaneous drain and grant (resp_valid & resp_ready & grant): new result loaded the same cycle.
//    Full throughput is 1 result/cycle.
//  - rr_ptr changes only on a grant; idle cycles do not move it.
//  - Requester contract: once req_valid is asserted, req_a/req_sh are held stable until req_ready.
//    The block is not required to check this.
//  - sh=0 gives resp_b=a. sh=Bits-1 gives resp_b={a[0],{Bits-1{1'b0}}}.
//  - Reset mid-operation: a pending result is dropped and rr_ptr returns to 0.
//    No handshake completes in the reset cycle.
//  - Fairness: with all requesters continuously valid and resp_ready=1, grants rotate 0,1,..,Nreq-1,0,...
// STRUCTURE
//  - Shared header/package: `log2 function macro, SHW/IDW width derivation.
//    Also holds a request-slice helper so requester packing is identical across users.
//  - One sub-module: shift_barrelfast_sleft (Bits passed through). It is instantiated once and
//    fed by the grant mux, unmodified.
//  - Local logic: round-robin priority picker (double-width mask trick or rotate + priority encode),
//    grant mux, output register, rr_ptr.
// TESTING
//  1. Reset: hold reset_n=0 with all req_valid=1 -> req_ready=0, resp_valid=0.
//     Release -> first grant goes to requester 0.
//  2. Single request: req 2 a=64'h1, sh=63, resp_ready=1 -> next cycle resp_valid=1,
//     resp_b=64'h8000_0000_0000_0000, resp_id=2.
//  3. Round robin: all 4 valid, resp_ready=1 for 8 cycles -> resp_id sequence 0,1,2,3,0,1,2,3,
//     one result per cycle.
//  4. Backpressure: result pending, resp_ready=0 for 3 cycles -> req_ready=0, resp_b/resp_id stable.
//     Raise resp_ready -> drain and new grant in the same cycle.
//  5. Pointer: req 3 granted, then only req 1 and req 3 valid -> req 1 granted next (wraps past 0).
//  6. Reset mid-flight: assert reset_n=0 while resp_valid=1 and resp_ready=0 -> resp_valid drops
//     immediately (async). After release, rr_ptr=0.
//  - Scoreboard: random reqs/backpressure against reference model (a<<sh)&mask.
//    Check no lost or duplicated requests and resp_id matches the granted index.

Source files
------------

// File: rtl/shift_barrel_arbiter_pkg.sv
// ============================================================================
// shift_barrel_arbiter_pkg : width helpers and request-slice helper shared by
//                            the shift arbiter and its users
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif

package shift_barrel_arbiter_pkg;

  localparam int C_DEFAULT_BITS = 64;
  localparam int C_DEFAULT_NREQ = 4;

  function automatic int sh_width(input int bits);
    return `LOG2(bits);
  endfunction

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(input int nreq);
    return (nreq > 2) ? `LOG2(nreq) : 1;
  endfunction

  // LSB position of requester idx inside a packed per-requester bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_barrelfast_sleft.sv
// ============================================================================
// shift_barrelfast_sleft : combinational log-depth left barrel shifter,
//                          zero-filled, result truncated to Bits
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_barrelfast_sleft
  import shift_barrel_arbiter_pkg::*;
#(
  parameter int Bits = C_DEFAULT_BITS,
  localparam int SHW = sh_width(Bits)
) (
  input  logic [Bits-1:0] i_a,
  input  logic [SHW-1:0]  i_sh,
  output logic [Bits-1:0] o_y
);

  logic [Bits-1:0] w_stage [SHW+1];

  assign w_stage[0] = i_a;

  // Stage k conditionally shifts by 2**k, so SHW stages cover 0..Bits-1.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int C_AMT = 1 << k;
    assign w_stage[k+1] = i_sh[k] ? {w_stage[k][Bits-1-C_AMT:0], {C_AMT{1'b0}}}
                                  : w_stage[k];
  end

  assign o_y = w_stage[SHW];

endmodule

`default_nettype wire

// File: rtl/shift_barrel_arbiter.sv
// ============================================================================
// shift_barrel_arbiter : round-robin sharing of one barrel shifter among Nreq
//                        requesters, single registered tagged response slot
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_barrel_arbiter
  import shift_barrel_arbiter_pkg::*;
#(
  parameter int Bits = C_DEFAULT_BITS,
  parameter int Nreq = C_DEFAULT_NREQ,
  localparam int SHW = sh_width(Bits),
  localparam int IDW = id_width(Nreq)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [Nreq-1:0]      req_valid,
  output logic [Nreq-1:0]      req_ready,
  input  logic [Nreq*Bits-1:0] req_a,
  input  logic [Nreq*SHW-1:0]  req_sh,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [Bits-1:0]      resp_b,
  output logic [IDW-1:0]       resp_id
);

  localparam logic [IDW-1:0] C_LAST = IDW'(Nreq - 1);

  logic            r_resp_valid;
  logic [Bits-1:0] r_resp_b;
  logic [IDW-1:0]  r_resp_id;
  logic [IDW-1:0]  r_rr_ptr;

  logic            w_can_accept;
  logic            w_found;
  logic            w_grant;
  logic [IDW-1:0]  w_gnt_idx;
  logic [IDW-1:0]  w_cand;
  logic [IDW-1:0]  w_ptr_next;
  logic [Bits-1:0] w_sel_a;
  logic [SHW-1:0]  w_sel_sh;
  logic [Bits-1:0] w_shifted;

  logic [Bits-1:0] w_a_arr  [Nreq];
  logic [SHW-1:0]  w_sh_arr [Nreq];

  for (genvar i = 0; i < Nreq; i++) begin : g_unpack
    assign w_a_arr[i]  = req_a[slice_lo(i, Bits) +: Bits];
    assign w_sh_arr[i] = req_sh[slice_lo(i, SHW) +: SHW];
  end

  // Circular scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int off = 0; off < Nreq; off++) begin
      w_cand = IDW'((int'(r_rr_ptr) + off) % Nreq);
      if (!w_found && req_valid[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_can_accept = !r_resp_valid || resp_ready;
  assign w_grant      = reset_n && w_can_accept && w_found;

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign w_sel_a    = w_a_arr[w_gnt_idx];
  assign w_sel_sh   = w_sh_arr[w_gnt_idx];
  assign w_ptr_next = (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + IDW'(1);

  shift_barrelfast_sleft #(
    .Bits (Bits)
  ) u_shift (
    .i_a  (w_sel_a),
    .i_sh (w_sel_sh),
    .o_y  (w_shifted)
  );

  // A grant reloads the slot even while the old result drains this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid <= 1'b0;
      r_resp_b     <= '0;
      r_resp_id    <= '0;
      r_rr_ptr     <= '0;
    end else if (w_grant) begin
      r_resp_valid <= 1'b1;
      r_resp_b     <= w_shifted;
      r_resp_id    <= w_gnt_idx;
      r_rr_ptr     <= w_ptr_next;
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_b     = r_resp_b;
  assign resp_id    = r_resp_id;

endmodule

`default_nettype wire
